// File: rtl/game_control_multi_pkg.sv
// Shared types and constants for the multi-pipe flappy game controller:
// state encoding, coordinate widths and the hole-placement LFSR.
package game_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  // Galois form, taps 16,14,13,11, shifting right
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/game_control_multi_if.sv
// Controller-to-renderer bundle: frame sync and button in, game geometry,
// scores and state out.
interface game_control_multi_if #(
  parameter int NUM_PIPES = 2,
  parameter int SCORE_W   = 8
);
  import game_pkg::*;

  logic                       v_sync;
  logic                       button;
  logic [Y_W-1:0]             bird_pos;
  logic [X_W*NUM_PIPES-1:0]   pipe_pos;
  logic [Y_W*NUM_PIPES-1:0]   hole_pos;
  logic [SCORE_W-1:0]         score;
  logic [SCORE_W-1:0]         high_score;
  logic [1:0]                 game_state;

  modport master (
    input  v_sync, button,
    output bird_pos, pipe_pos, hole_pos, score, high_score, game_state
  );

  modport slave (
    output v_sync, button,
    input  bird_pos, pipe_pos, hole_pos, score, high_score, game_state
  );

endinterface

// File: rtl/game_control_multi_frame_tick.sv
// Falling-edge detect on v_sync: one tick on the first clock after sync ends.
module game_frame_tick (
  input  logic clock,
  input  logic reset,
  input  logic v_sync,
  output logic tick
);

  logic v_sync_p0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) v_sync_p0 <= 1'b0;
    else        v_sync_p0 <= v_sync;
  end

  assign tick = v_sync_p0 & ~v_sync;

endmodule

// File: rtl/game_control_multi.sv
// Per-frame game controller: bird physics, NUM_PIPES scrolling pipes,
// scoring, collision and a persistent high score, all advanced once per tick.
module game_control_multi
  import game_pkg::*;
#(
  parameter int NUM_PIPES  = 2,
  parameter int PIPE_START = 600,
  parameter int PIPE_GAP_X = 370,
  parameter int PIPE_WRAP  = 740,
  parameter int PIPE_SPEED = 4,
  parameter int BIRD_START = 265,
  parameter int FLAP_VEL   = -11,
  parameter int MAX_FALL   = 8,
  parameter int FLOOR_Y    = 480,
  parameter int HIT_X_LO   = 50,
  parameter int HIT_X_HI   = 200,
  parameter int GAP_LO     = 50,
  parameter int GAP_HI     = 150,
  parameter int HOLE_MIN   = 37,
  parameter int HOLE_INIT  = 165,
  parameter int SCORE_W    = 8
) (
  input logic clock,
  input logic reset,
  game_control_multi_if.master gif
);

  localparam int YE_W = Y_W + 1;
  localparam logic signed [5:0] FLAP_V = 6'(FLAP_VEL);
  localparam logic signed [5:0] MAX_V  = 6'(MAX_FALL);
  localparam logic [Y_W-1:0]    FLOOR  = Y_W'(FLOOR_Y);
  localparam logic [Y_W-1:0]    BIRD0  = Y_W'(BIRD_START);
  localparam logic [Y_W-1:0]    HOLE0  = Y_W'(HOLE_INIT);

  function automatic logic signed [5:0] vel_sat(input logic signed [5:0] v);
    return (v >= MAX_V) ? MAX_V : v + 6'sd1;
  endfunction

  // bird + signed velocity, clamped into [0, 2^Y_W-1]
  function automatic logic [Y_W-1:0] bird_sat(input logic [Y_W-1:0] b,
                                              input logic signed [5:0] v);
    logic signed [Y_W+1:0] s;
    s = $signed({2'b00, b}) + $signed({{(Y_W-4){v[5]}}, v});
    if (s[Y_W+1])  return '0;
    else if (s[Y_W]) return '1;
    else           return s[Y_W-1:0];
  endfunction

  function automatic logic [SCORE_W-1:0] score_sat(input logic [SCORE_W-1:0] s,
                                                   input logic [NUM_PIPES-1:0] w);
    logic [SCORE_W-1:0] r;
    r = s;
    for (int k = 0; k < NUM_PIPES; k++)
      if (w[k] && r != '1) r = r + SCORE_W'(1);
    return r;
  endfunction

  function automatic logic [X_W-1:0] pipe_start(input int i);
    return X_W'(PIPE_START + i * PIPE_GAP_X);
  endfunction

  logic                  tick;
  game_state_e           state_q;
  logic [Y_W-1:0]        bird_q;
  logic signed [5:0]     vel_q;
  logic [X_W-1:0]        pipe_q [NUM_PIPES];
  logic [Y_W-1:0]        hole_q [NUM_PIPES];
  logic [X_W-1:0]        pipe_nx [NUM_PIPES];
  logic [Y_W-1:0]        hole_nx [NUM_PIPES];
  logic [NUM_PIPES-1:0]  wrap_v;
  logic [NUM_PIPES-1:0]  hit_v;
  logic [SCORE_W-1:0]    score_q;
  logic [SCORE_W-1:0]    high_q;
  logic                  armed_q;
  logic [15:0]           lfsr_q;
  logic                  flap;
  logic                  collide;

  game_frame_tick u_tick (
    .clock  (clock),
    .reset  (reset),
    .v_sync (gif.v_sync),
    .tick   (tick)
  );

  assign flap = tick & ~gif.button & armed_q;

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
    logic [YE_W-1:0] band_lo;
    logic [YE_W-1:0] band_hi;
    logic            in_band;

    assign wrap_v[i]  = pipe_q[i] < X_W'(PIPE_SPEED);
    assign pipe_nx[i] = wrap_v[i] ? X_W'(PIPE_WRAP) : pipe_q[i] - X_W'(PIPE_SPEED);
    assign hole_nx[i] = wrap_v[i] ? Y_W'(HOLE_MIN) + {1'b0, lfsr_q[7:0]} : hole_q[i];

    // widened by one bit so hole+offset never wraps
    assign band_lo = {1'b0, hole_q[i]} + YE_W'(GAP_LO);
    assign band_hi = {1'b0, hole_q[i]} + YE_W'(GAP_HI);
    assign in_band = ({1'b0, bird_q} > band_lo) && ({1'b0, bird_q} < band_hi);
    assign hit_v[i] = (pipe_q[i] > X_W'(HIT_X_LO)) && (pipe_q[i] < X_W'(HIT_X_HI)) && !in_band;

    assign gif.pipe_pos[X_W*i +: X_W] = pipe_q[i];
    assign gif.hole_pos[Y_W*i +: Y_W] = hole_q[i];
  end

  assign collide = (bird_q >= FLOOR) || (|hit_v);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      bird_q  <= BIRD0;
      vel_q   <= '0;
      score_q <= '0;
      high_q  <= '0;
      armed_q <= 1'b1;
      lfsr_q  <= LFSR_SEED;
      for (int i = 0; i < NUM_PIPES; i++) begin
        pipe_q[i] <= pipe_start(i);
        hole_q[i] <= HOLE0;
      end
    end else if (tick) begin
      lfsr_q  <= lfsr_next(lfsr_q);
      // a held button keeps armed low, so holding yields a single flap
      armed_q <= gif.button;
      unique case (state_q)
        ST_IDLE: begin
          if (flap) begin
            state_q <= ST_PLAY;
            vel_q   <= FLAP_V;
          end
        end
        ST_PLAY: begin
          vel_q  <= flap ? FLAP_V : vel_sat(vel_q);
          bird_q <= bird_sat(bird_q, vel_q);
          if (collide) begin
            state_q <= ST_DYING;
          end else begin
            score_q <= score_sat(score_q, wrap_v);
            for (int i = 0; i < NUM_PIPES; i++) begin
              pipe_q[i] <= pipe_nx[i];
              hole_q[i] <= hole_nx[i];
            end
          end
        end
        ST_DYING: begin
          if (bird_q >= FLOOR) begin
            bird_q  <= FLOOR;
            state_q <= ST_OVER;
            if (score_q > high_q) high_q <= score_q;
          end else begin
            bird_q <= bird_sat(bird_q, vel_q);
            vel_q  <= vel_sat(vel_q);
          end
        end
        ST_OVER: begin
          if (flap) begin
            state_q <= ST_IDLE;
            bird_q  <= BIRD0;
            vel_q   <= '0;
            score_q <= '0;
            for (int i = 0; i < NUM_PIPES; i++) begin
              pipe_q[i] <= pipe_start(i);
              hole_q[i] <= HOLE0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gif.bird_pos   = bird_q;
  assign gif.score      = score_q;
  assign gif.high_score = high_q;
  assign gif.game_state = state_q;

endmodule
